// File: rtl/vga_scanout_if.sv
// Pixel-write bus from the game datapath into the scan-out engine.
// One pixel (x, y, colour) is written per clock while plot is high.
interface vga_scanout_if;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 320x240x3 framebuffer with a 640x480@60 VGA scan-out engine.
// Stored pixels are doubled 2x2. The scan runs at half the system clock
// (pix_en), through a 3-stage pipeline: address, RAM data, output colour.
// HS/VS/BLANK_N travel through matching delay stages so all outputs line up.
module vga_scanout #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SP  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SP  = 2,
    parameter int V_BP  = 33
) (
    input  logic              clk,
    input  logic              resetn,
    vga_scanout_if.slave      wr,
    output logic              o_vga_clk,
    output logic              o_vga_hs,
    output logic              o_vga_vs,
    output logic              o_vga_blank_n,
    output logic              o_vga_sync_n,
    output logic [7:0]        o_vga_r,
    output logic [7:0]        o_vga_g,
    output logic [7:0]        o_vga_b,
    output logic              o_vblank_start
);

    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SP + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SP + V_BP - 1);
    localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] H_SYNC_S   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_E   = 10'(H_VIS + H_FP + H_SP - 1);
    localparam logic [9:0] V_SYNC_S   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_E   = 10'(V_VIS + V_FP + V_SP - 1);

    // Framebuffer: not reset, so game graphics survive a scan reset.
    logic [2:0]  r_mem [0:76799];

    logic        r_pix_en;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    // Stage 1: read address and sync/blank decoded from the counters.
    logic [16:0] r_addr;
    logic        r_hs1, r_vs1, r_vis1;
    // Stage 2: RAM data and delayed sync/blank.
    logic [2:0]  r_ram_q;
    logic        r_hs2, r_vs2, r_vis2;
    // Stage 3: output registers.
    logic        r_hs3, r_vs3, r_vis3;
    logic [7:0]  r_r, r_g, r_b;
    logic        r_vga_clk;
    logic        r_vblank;

    logic        w_wr_ok;
    logic [16:0] w_waddr;
    logic [16:0] w_y_ext;
    logic [16:0] w_v_half;
    logic [16:0] w_h_half;
    logic [16:0] w_raddr;
    logic        w_vis;
    logic        w_hs_n;
    logic        w_vs_n;

    // y*320 + x done as shifts; out-of-range writes never reach the RAM.
    assign w_wr_ok  = wr.plot && (wr.x < 9'd320) && (wr.y < 8'd240);
    assign w_y_ext  = {9'd0, wr.y};
    assign w_waddr  = (w_y_ext << 8) + (w_y_ext << 6) + {8'd0, wr.x};

    // Each stored pixel covers 2x2 screen pixels, hence the halved counters.
    assign w_v_half = {8'd0, r_vcnt[9:1]};
    assign w_h_half = {8'd0, r_hcnt[9:1]};
    assign w_raddr  = (w_v_half << 8) + (w_v_half << 6) + w_h_half;

    assign w_vis    = (r_hcnt < H_VIS_L) && (r_vcnt < V_VIS_L);
    assign w_hs_n   = !((r_hcnt >= H_SYNC_S) && (r_hcnt <= H_SYNC_E));
    assign w_vs_n   = !((r_vcnt >= V_SYNC_S) && (r_vcnt <= V_SYNC_E));

    // Framebuffer write port; a same-edge read of this address sees old data.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_waddr] <= wr.colour;
        end
    end

    // Pixel enable, counters, scan pipeline and vblank pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
            r_vblank  <= 1'b0;
            r_hcnt    <= 10'd0;
            r_vcnt    <= 10'd0;
            r_addr    <= 17'd0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_vis1    <= 1'b0;
            r_ram_q   <= 3'd0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_vis2    <= 1'b0;
            r_hs3     <= 1'b1;
            r_vs3     <= 1'b1;
            r_vis3    <= 1'b0;
            r_r       <= 8'd0;
            r_g       <= 8'd0;
            r_b       <= 8'd0;
        end else begin
            r_pix_en  <= ~r_pix_en;
            r_vga_clk <= r_pix_en;
            // Registered one cycle early so the pulse lands in the pix_en=1
            // half of the last active-line position.
            r_vblank  <= !r_pix_en && (r_hcnt == H_LAST) && (r_vcnt == V_VIS_LAST);
            if (r_pix_en) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= 10'd0;
                    r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
                r_addr  <= w_vis ? w_raddr : 17'd0;
                r_hs1   <= w_hs_n;
                r_vs1   <= w_vs_n;
                r_vis1  <= w_vis;
                r_ram_q <= r_mem[r_addr];
                r_hs2   <= r_hs1;
                r_vs2   <= r_vs1;
                r_vis2  <= r_vis1;
                r_hs3   <= r_hs2;
                r_vs3   <= r_vs2;
                r_vis3  <= r_vis2;
                r_r     <= {8{r_ram_q[2] & r_vis2}};
                r_g     <= {8{r_ram_q[1] & r_vis2}};
                r_b     <= {8{r_ram_q[0] & r_vis2}};
            end
        end
    end

    assign o_vga_clk      = r_vga_clk;
    assign o_vga_hs       = r_hs3;
    assign o_vga_vs       = r_vs3;
    assign o_vga_blank_n  = r_vis3;
    assign o_vga_sync_n   = 1'b0;
    assign o_vga_r        = r_r;
    assign o_vga_g        = r_g;
    assign o_vga_b        = r_b;
    assign o_vblank_start = r_vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-timing instance exercised over several
// frames against a behavioural screen model, plus a default-timing instance
// whose first line is measured directly.
module tb_vga_scanout;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 80
    localparam int VT = VV + VF + VS + VB;   // 30
    localparam int FRAME = 2 * HT * VT;      // 4800 clk

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    vga_scanout_if bus ();
    vga_scanout_if bus0 ();

    logic       vclk, hs, vs, blank_n, sync_n, vb;
    logic [7:0] r, g, b;
    logic       vclk0, hs0, vs0, blank_n0, sync_n0, vb0;
    logic [7:0] r0, g0, b0;

    vga_scanout #(.H_VIS(HV), .H_FP(HF), .H_SP(HS), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SP(VS), .V_BP(VB)) u_dut (
        .clk(clk), .resetn(resetn), .wr(bus),
        .o_vga_clk(vclk), .o_vga_hs(hs), .o_vga_vs(vs), .o_vga_blank_n(blank_n),
        .o_vga_sync_n(sync_n), .o_vga_r(r), .o_vga_g(g), .o_vga_b(b),
        .o_vblank_start(vb));

    vga_scanout u_dut0 (
        .clk(clk), .resetn(resetn), .wr(bus0),
        .o_vga_clk(vclk0), .o_vga_hs(hs0), .o_vga_vs(vs0), .o_vga_blank_n(blank_n0),
        .o_vga_sync_n(sync_n0), .o_vga_r(r0), .o_vga_g(g0), .o_vga_b(b0),
        .o_vblank_start(vb0));

    int     checks = 0;
    int     errors = 0;
    int     nprint = 0;
    bit     cmp_en = 1'b0;
    int     cyc = 0;      // clk cycles since reset release (0 while in reset)
    longint tick = 0;     // absolute edge count, never reset
    int     vb_cyc[$];

    // Model framebuffer: latest value, previous value and the edge it landed on.
    logic [2:0] fb_new [0:76799];
    logic [2:0] fb_old [0:76799];
    longint     fb_wt  [0:76799];

    always @(posedge clk) begin
        tick <= tick + 1;
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Expected {sync_n, vga_clk, hs, vs, blank_n, r, g, b, vblank} in cycle n.
    function automatic logic [29:0] model(input int n, input longint t,
                                          input int hv, hf, hsp, hbp,
                                          input int vv, vf, vsp, vbp,
                                          input bit use_fb);
        int ht, vt, p, h, v, a, p2;
        logic e_hs, e_vs, e_bl, e_vclk, e_vb;
        logic [2:0] c;
        longint rt;
        ht = hv + hf + hsp + hbp;
        vt = vv + vf + vsp + vbp;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; c = 3'd0;
        if (n >= 6) begin
            p = (n - 6) / 2;
            h = p % ht;
            v = (p / ht) % vt;
            e_hs = !(h >= hv + hf && h < hv + hf + hsp);
            e_vs = !(v >= vv + vf && v < vv + vf + vsp);
            e_bl = (h < hv) && (v < vv);
            if (e_bl && use_fb) begin
                a  = (v / 2) * 320 + (h / 2);
                rt = t - longint'(n) + longint'(2 * p + 3);  // edge that read the RAM
                c  = (fb_wt[a] < rt) ? fb_new[a] : fb_old[a];
            end
        end
        e_vclk = (n > 0) && (n % 2 == 0);
        e_vb = 1'b0;
        if (n % 2 == 1) begin
            p2 = (n - 1) / 2;
            e_vb = (p2 % ht == ht - 1) && ((p2 / ht) % vt == vv - 1);
        end
        return {1'b0, e_vclk, e_hs, e_vs, e_bl,
                {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, e_vb};
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [29:0] e, e0, q, q0;
        if (cmp_en) begin
            e  = model(cyc, tick, HV, HF, HS, HB, VV, VF, VS, VB, 1'b1);
            e0 = model(cyc, tick, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            q  = {sync_n, vclk, hs, vs, blank_n, r, g, b, vb};
            q0 = {sync_n0, vclk0, hs0, vs0, blank_n0, r0, g0, b0, vb0};
            checks = checks + 2;
            if (q !== e) begin
                errors = errors + 1;
                if (nprint < 20) $display("FAIL scan cyc=%0d got=%h expected=%h", cyc, q, e);
                nprint = nprint + 1;
            end
            if (q0 !== e0) begin
                errors = errors + 1;
                if (nprint < 20) $display("FAIL scan_default cyc=%0d got=%h expected=%h", cyc, q0, e0);
                nprint = nprint + 1;
            end
            if (vb) vb_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
        chk("wait_cyc", cyc, target);
    endtask

    task automatic write_px(input int x, input int y, input logic [2:0] c);
        int a;
        bus.x = 9'(x); bus.y = 8'(y); bus.colour = c; bus.plot = 1'b1;
        if (x < 320 && y < 240) begin
            a = y * 320 + x;
            fb_old[a] = fb_new[a];
            fb_new[a] = c;
            fb_wt[a]  = tick;   // lands on the edge ending this cycle
        end
        @(negedge clk);
        bus.plot = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {hs, vs, blank_n, vclk, vb, r, g, b}, {5'b11000, 24'h0});
    endtask

    initial begin
        int hs_first, hs_low, hs0_first, hs0_low, bl0_high;
        for (int i = 0; i < 76800; i++) begin
            fb_new[i] = 3'd0; fb_old[i] = 3'd0; fb_wt[i] = 0;
        end
        bus.x = 9'd0;  bus.y = 8'd0;  bus.colour = 3'd0;  bus.plot = 1'b0;
        bus0.x = 9'd0; bus0.y = 8'd0; bus0.colour = 3'd0; bus0.plot = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk_reset_vals("reset_values");
        resetn = 1'b1;

        // First line: sync and blank widths on both instances.
        hs_first = -1; hs_low = 0; hs0_first = -1; hs0_low = 0; bl0_high = 0;
        while (cyc < 1606) begin
            @(negedge clk);
            if (!hs && hs_first < 0) hs_first = cyc;
            if (!hs0 && hs0_first < 0) hs0_first = cyc;
            if (cyc >= 6 && cyc < 166 && !hs) hs_low = hs_low + 1;
            if (cyc >= 6 && cyc < 1606) begin
                if (!hs0) hs0_low = hs0_low + 1;
                if (blank_n0) bl0_high = bl0_high + 1;
            end
        end
        chk("hs_first_small", hs_first, 142);
        chk("hs_low_small", hs_low, 16);
        chk("hs_first_default", hs0_first, 1318);
        chk("hs_low_default", hs0_low, 192);
        chk("blank_high_default", bl0_high, 1280);

        write_px(0, 0, 3'b100);
        write_px(31, 11, 3'b011);
        write_px(320, 0, 3'b111);   // dropped; would alias to (0,1)
        write_px(0, 240, 3'b111);   // dropped
        write_px(5, 3, 3'b010);
        write_px(1, 0, 3'b001);

        // Frame 1 hand-computed pixels.
        wait_cyc(4806); chk("px_0_0", {r, g, b}, 24'hFF0000);
        wait_cyc(4810); chk("px_2_0", {r, g, b}, 24'h0000FF);
        wait_cyc(4968); chk("px_1_1", {r, g, b}, 24'hFF0000);
        wait_cyc(5126); chk("px_0_2_oob", {r, g, b}, 24'h000000);
        wait_cyc(8450); chk("px_62_22", {r, g, b}, 24'h00FFFF);

        wait_cyc(3 * FRAME);
        chk("vblank_count", vb_cyc.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
        if (vb_cyc.size() >= 3) begin
            chk("vblank_first", vb_cyc[0], 3839);
            chk("vblank_gap1", vb_cyc[1] - vb_cyc[0], FRAME);
            chk("vblank_gap2", vb_cyc[2] - vb_cyc[1], FRAME);
        end

        // Write (10,10) on the edge of the last read of address 3210 in frame 3.
        wait_cyc(17805);
        write_px(10, 10, 3'b111);
        wait_cyc(17808); chk("collision_old", {r, g, b}, 24'h000000);
        wait_cyc(22446); chk("collision_new", {r, g, b}, 24'hFFFFFF);

        // One-clock reset mid-frame.
        wait_cyc(23100);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_vals("midframe_reset");
        resetn = 1'b1;
        wait_cyc(6);    chk("post_rst_px_0_0", {r, g, b}, 24'hFF0000);
        wait_cyc(3246); chk("post_rst_px_20_20", {r, g, b}, 24'hFFFFFF);
        while (vs && cyc < 6000) @(negedge clk);
        chk("vs_first_after_rst", cyc, 4166);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
